// File: rtl/overflow_req_gen.sv
// Per-channel overflow-interval timestamper: captures start/end LTC of each overflow
// interval and hands it to the shared FIFO controller over a 4-phase req/ack.
module overflow_req_gen #(
  parameter int P_LTC_WIDTH      = 48,
  parameter int P_DROP_CNT_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [P_LTC_WIDTH-1:0]      ltc_in,
  input  logic                        overflow_in,
  input  logic                        ack,
  output logic                        req,
  output logic [P_LTC_WIDTH-1:0]      overflow_start_ltc,
  output logic [P_LTC_WIDTH-1:0]      overflow_end_ltc,
  output logic [P_DROP_CNT_WIDTH-1:0] drop_count,
  output logic                        busy
);

  typedef enum logic [1:0] {
    S_IDLE         = 2'd0,
    S_REQ          = 2'd1,
    S_WAIT_ACK_LOW = 2'd2
  } state_t;

  localparam logic [P_DROP_CNT_WIDTH-1:0] DROP_MAX = {P_DROP_CNT_WIDTH{1'b1}};

  state_t                   state, state_nxt;
  logic                     load_outputs;

  logic                     ovf_q;
  logic                     ovf_rise;
  logic                     ovf_fall;
  logic [P_LTC_WIDTH-1:0]   start_cap;

  logic                     pending_valid;
  logic [P_LTC_WIDTH-1:0]   pending_start;
  logic [P_LTC_WIDTH-1:0]   pending_end;
  logic                     pending_accept;

  assign ovf_rise = overflow_in & ~ovf_q;
  assign ovf_fall = ~overflow_in & ovf_q;

  // A completing interval may refill the slot in the same cycle the FSM drains it.
  assign pending_accept = ovf_fall & (~pending_valid | load_outputs);

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= overflow_in;
    end
  end

  // NOTE: pure data registers are not reset; their validity is carried by ovf_q/pending_valid.
  always_ff @(posedge clk) begin
    if (ovf_rise) begin
      start_cap <= ltc_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_valid <= 1'b0;
    end else if (pending_accept) begin
      pending_valid <= 1'b1;
    end else if (load_outputs) begin
      pending_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (pending_accept) begin
      pending_start <= start_cap;
      pending_end   <= ltc_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_count <= '0;
    end else if (ovf_fall && !pending_accept && drop_count != DROP_MAX) begin
      drop_count <= drop_count + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every output of this block is defaulted first so no latch can be inferred.
  always_comb begin
    state_nxt    = state;
    load_outputs = 1'b0;
    case (state)
      S_IDLE: begin
        if (pending_valid) begin
          load_outputs = 1'b1;
          state_nxt    = S_REQ;
        end
      end
      S_REQ: begin
        if (ack) begin
          state_nxt = S_WAIT_ACK_LOW;
        end
      end
      S_WAIT_ACK_LOW: begin
        if (!ack) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs stay frozen from load until the handshake returns to idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_start_ltc <= '0;
      overflow_end_ltc   <= '0;
    end else if (load_outputs) begin
      overflow_start_ltc <= pending_start;
      overflow_end_ltc   <= pending_end;
    end
  end

  assign req  = (state == S_REQ);
  assign busy = (state != S_IDLE) | pending_valid;

endmodule

// File: tb/tb_overflow_req_gen.sv
// Directed bench for overflow_req_gen: handshake timing, pending slot, drops and reset.
module tb_overflow_req_gen;

  localparam int LW = 48;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [LW-1:0] ltc;
  logic          ovf;
  logic          ack;
  logic          req;
  logic [LW-1:0] start_ltc;
  logic [LW-1:0] end_ltc;
  logic [DW-1:0] drop;
  logic          busy;

  logic          ovf5;
  logic          ack5;
  logic          req5;
  logic [LW-1:0] start5;
  logic [LW-1:0] end5;
  logic [1:0]    drop5;
  logic          busy5;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  overflow_req_gen #(.P_LTC_WIDTH(LW), .P_DROP_CNT_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .ltc_in(ltc), .overflow_in(ovf), .ack(ack),
    .req(req), .overflow_start_ltc(start_ltc), .overflow_end_ltc(end_ltc),
    .drop_count(drop), .busy(busy)
  );

  overflow_req_gen #(.P_LTC_WIDTH(LW), .P_DROP_CNT_WIDTH(2)) dut5 (
    .clk(clk), .rst(rst), .ltc_in(ltc), .overflow_in(ovf5), .ack(ack5),
    .req(req5), .overflow_start_ltc(start5), .overflow_end_ltc(end5),
    .drop_count(drop5), .busy(busy5)
  );

  // One clock: inputs set before the call are sampled at this edge; ltc advances by one.
  task automatic tick();
    @(posedge clk);
    #1;
    ltc = ltc + 1;
  endtask

  task automatic do_reset();
    rst = 1'b1; ovf = 1'b0; ack = 1'b0; ovf5 = 1'b0; ack5 = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  // Interval of 'len' high cycles starting at ltc=s; falls at ltc=s+len, then one idle cycle.
  task automatic interval(input logic [LW-1:0] s, input int len);
    ltc = s; ovf = 1'b1;
    repeat (len) tick();
    ovf = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    ltc = 0;
    do_reset();
    n_cmp++; if (req !== 1'b0) begin n_err++; $display("FAIL rst_req: got %0b want 0", req); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %0b want 0", busy); end
    n_cmp++; if (start_ltc !== '0 || end_ltc !== '0) begin n_err++;
      $display("FAIL rst_ltc: got %0d/%0d want 0/0", start_ltc, end_ltc); end
    n_cmp++; if (drop !== '0) begin n_err++; $display("FAIL rst_drop: got %0d want 0", drop); end
  endtask

  task automatic test_single();
    do_reset();
    ltc = 100; ovf = 1'b1;
    repeat (10) tick();
    ovf = 1'b0;
    tick();
    n_cmp++; if (req !== 1'b0 || busy !== 1'b1) begin n_err++;
      $display("FAIL t1_pending: got req=%0b busy=%0b want 0/1", req, busy); end
    tick();
    n_cmp++; if (req !== 1'b1) begin n_err++; $display("FAIL t1_req_rise: got %0b want 1", req); end
    n_cmp++; if (start_ltc !== 100 || end_ltc !== 110) begin n_err++;
      $display("FAIL t1_ltc: got %0d/%0d want 100/110", start_ltc, end_ltc); end
    tick(); tick();
    n_cmp++; if (req !== 1'b1) begin n_err++; $display("FAIL t1_req_held: got %0b want 1", req); end
    ack = 1'b1;
    tick();
    n_cmp++; if (req !== 1'b0 || busy !== 1'b1) begin n_err++;
      $display("FAIL t1_req_fall: got req=%0b busy=%0b want 0/1", req, busy); end
    ack = 1'b0;
    tick();
    n_cmp++; if (busy !== 1'b0 || start_ltc !== 100 || end_ltc !== 110) begin n_err++;
      $display("FAIL t1_idle: got busy=%0b ltc=%0d/%0d want 0 100/110", busy, start_ltc, end_ltc); end
  endtask

  task automatic test_pending_drop();
    do_reset();
    interval(10, 2);
    interval(20, 2);
    interval(30, 2);
    n_cmp++; if (drop !== 1) begin n_err++; $display("FAIL t2_drop: got %0d want 1", drop); end
    n_cmp++; if (req !== 1'b1 || start_ltc !== 10 || end_ltc !== 12) begin n_err++;
      $display("FAIL t2_first: got req=%0b ltc=%0d/%0d want 1 10/12", req, start_ltc, end_ltc); end
    ack = 1'b1; tick();
    ack = 1'b0; tick(); tick();
    n_cmp++; if (req !== 1'b1 || start_ltc !== 20 || end_ltc !== 22) begin n_err++;
      $display("FAIL t2_second: got req=%0b ltc=%0d/%0d want 1 20/22", req, start_ltc, end_ltc); end
    ack = 1'b1; tick();
    ack = 1'b0; tick(); tick();
    n_cmp++; if (busy !== 1'b0 || req !== 1'b0 || drop !== 1) begin n_err++;
      $display("FAIL t2_drained: got busy=%0b req=%0b drop=%0d want 0 0 1", busy, req, drop); end
  endtask

  task automatic test_ack_hold();
    int seen_req;
    do_reset();
    interval(40, 3);
    interval(50, 3);
    ack = 1'b1;
    seen_req = 0;
    repeat (20) begin
      tick();
      if (req !== 1'b0) seen_req++;
    end
    n_cmp++; if (seen_req !== 0 || busy !== 1'b1) begin n_err++;
      $display("FAIL t3_ack_hold: got req_cycles=%0d busy=%0b want 0/1", seen_req, busy); end
    ack = 1'b0;
    tick();
    n_cmp++; if (req !== 1'b0) begin n_err++; $display("FAIL t3_gap: got %0b want 0", req); end
    tick();
    n_cmp++; if (req !== 1'b1 || start_ltc !== 50 || end_ltc !== 53) begin n_err++;
      $display("FAIL t3_next: got req=%0b ltc=%0d/%0d want 1 50/53", req, start_ltc, end_ltc); end
  endtask

  task automatic test_reset_mid();
    int seen_req;
    do_reset();
    interval(60, 2);
    interval(70, 2);
    n_cmp++; if (req !== 1'b1 || drop !== 0) begin n_err++;
      $display("FAIL t4_setup: got req=%0b drop=%0d want 1 0", req, drop); end
    rst = 1'b1;
    tick();
    n_cmp++; if (req !== 1'b0 || busy !== 1'b0 || drop !== 0) begin n_err++;
      $display("FAIL t4_rst: got req=%0b busy=%0b drop=%0d want 0 0 0", req, busy, drop); end
    rst = 1'b0;
    seen_req = 0;
    repeat (8) begin
      tick();
      if (req !== 1'b0 || busy !== 1'b0) seen_req++;
    end
    n_cmp++; if (seen_req !== 0) begin n_err++;
      $display("FAIL t4_quiet: got active_cycles=%0d want 0", seen_req); end
  endtask

  task automatic test_ack_idle();
    int seen_req;
    do_reset();
    ack = 1'b1;
    seen_req = 0;
    repeat (5) begin
      tick();
      if (req !== 1'b0 || busy !== 1'b0) seen_req++;
    end
    ack = 1'b0;
    n_cmp++; if (seen_req !== 0) begin n_err++;
      $display("FAIL idle_ack: got active_cycles=%0d want 0", seen_req); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    ltc = 10; ovf = 1'b1; tick();
    ovf = 1'b0; tick();
    tick();
    ltc = 20; ovf = 1'b1; tick();
    ovf = 1'b0; tick();
    ltc = 30; ovf = 1'b1; tick();
    ack = 1'b1; tick();
    ack = 1'b0; tick();
    ltc = 40; ovf = 1'b0; tick();
    n_cmp++; if (req !== 1'b1 || start_ltc !== 20 || end_ltc !== 21 || drop !== 0) begin n_err++;
      $display("FAIL b2b_load: got req=%0b ltc=%0d/%0d drop=%0d want 1 20/21 0",
               req, start_ltc, end_ltc, drop); end
    ack = 1'b1; tick();
    ack = 1'b0; tick(); tick();
    n_cmp++; if (req !== 1'b1 || start_ltc !== 30 || end_ltc !== 40 || drop !== 0) begin n_err++;
      $display("FAIL b2b_refill: got req=%0b ltc=%0d/%0d drop=%0d want 1 30/40 0",
               req, start_ltc, end_ltc, drop); end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      ltc = 200 + 10 * i; ovf5 = 1'b1;
      tick(); tick();
      ovf5 = 1'b0;
      tick(); tick();
      if (i == 3) begin
        n_cmp++; if (drop5 !== 2'd2) begin n_err++;
          $display("FAIL t5_drop_mid: got %0d want 2", drop5); end
      end
    end
    n_cmp++; if (drop5 !== 2'd3) begin n_err++; $display("FAIL t5_sat: got %0d want 3", drop5); end
    n_cmp++; if (req5 !== 1'b1 || start5 !== 200 || end5 !== 202) begin n_err++;
      $display("FAIL t5_first: got req=%0b ltc=%0d/%0d want 1 200/202", req5, start5, end5); end
  endtask

  task automatic test_ovf_at_reset();
    rst = 1'b1; ovf = 1'b1; ack = 1'b0;
    tick(); tick();
    rst = 1'b0;
    ltc = 500;
    repeat (7) tick();
    ovf = 1'b0;
    tick(); tick();
    n_cmp++; if (req !== 1'b1 || start_ltc !== 500 || end_ltc !== 507) begin n_err++;
      $display("FAIL t6_ltc: got req=%0b ltc=%0d/%0d want 1 500/507", req, start_ltc, end_ltc); end
  endtask

  initial begin
    rst = 1'b1; ovf = 1'b0; ack = 1'b0; ovf5 = 1'b0; ack5 = 1'b0; ltc = '0;
    test_reset();
    test_single();
    test_pending_drop();
    test_ack_hold();
    test_reset_mid();
    test_ack_idle();
    test_back_to_back();
    test_saturate();
    test_ovf_at_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
